// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with frame-level debounce and a FWFT key-code FIFO.
// Optional macro KEY_REPEAT_EN adds typematic re-push of the held key.
module keypad_scan_fifo #(
  parameter int ROWS            = 4,
  parameter int COLS            = 3,
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4,
`ifdef KEY_REPEAT_EN
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8,
`endif
  localparam int KEY_W = $clog2(ROWS*COLS),
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  output logic [ROWS-1:0]  row_out,
  input  logic [COLS-1:0]  col_in,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             held,
  output logic [KEY_W-1:0] held_code,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int DWELL_W = $clog2(SCAN_CYCLES);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  logic [COLS-1:0]  col_meta, col_sync;
  logic [ROW_W-1:0] row_idx;
  logic [DWELL_W-1:0] dwell;
  logic             row_last, frame_end;
  logic             hit, acc_found, frame_hit;
  logic [KEY_W-1:0] low_col, sample_code, acc_code, frame_code;

  state_t           state, state_nx;
  logic [KEY_W-1:0] cand, cand_nx;
  logic [3:0]       stable_cnt, stable_nx, rel_cnt, rel_nx;
  logic             confirm, push;

  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nx;
  logic [CNT_W-1:0] count_nx;
  logic [KEY_W-1:0] head_nx, push_code;
  logic             pop, full, push_ok;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      col_meta <= '0;
      col_sync <= '0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  assign row_last  = (dwell == DWELL_W'(SCAN_CYCLES - 1));
  assign frame_end = row_last && (row_idx == ROW_W'(ROWS - 1));
  assign row_out   = ROWS'(1) << row_idx;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      row_idx <= '0;
      dwell   <= '0;
    end else if (row_last) begin
      dwell   <= '0;
      row_idx <= (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + ROW_W'(1);
    end else begin
      dwell <= dwell + DWELL_W'(1);
    end
  end

  // Lowest pressed column on the current row; earlier rows win across a frame.
  always_comb begin
    hit     = |col_sync;
    low_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_sync[c]) low_col = KEY_W'(c);
    end
    sample_code = KEY_W'(row_idx) * KEY_W'(COLS) + low_col;
    frame_hit   = acc_found | hit;
    frame_code  = acc_found ? acc_code : sample_code;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc_found <= 1'b0;
      acc_code  <= '0;
    end else if (frame_end) begin
      acc_found <= 1'b0;
      acc_code  <= '0;
    end else if (row_last && !acc_found && hit) begin
      acc_found <= 1'b1;
      acc_code  <= sample_code;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      cand       <= '0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
    end else begin
      state      <= state_nx;
      cand       <= cand_nx;
      stable_cnt <= stable_nx;
      rel_cnt    <= rel_nx;
    end
  end

  // A mismatching key during press debounce restarts the run on that key.
  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    stable_nx = stable_cnt;
    rel_nx    = rel_cnt;
    confirm   = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_hit) begin
            cand_nx   = frame_code;
            stable_nx = 4'd1;
            if (DB_CNT == 4'd1) begin
              state_nx = HELD;
              confirm  = 1'b1;
            end else begin
              state_nx = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (frame_hit && frame_code == cand) begin
            stable_nx = stable_cnt + 4'd1;
            if (stable_nx == DB_CNT) begin
              state_nx = HELD;
              confirm  = 1'b1;
            end
          end else if (frame_hit) begin
            cand_nx   = frame_code;
            stable_nx = 4'd1;
          end else begin
            state_nx  = IDLE;
            stable_nx = 4'd0;
          end
        end
        HELD: begin
          if (!frame_hit || frame_code != cand) begin
            if (DB_CNT == 4'd1) begin
              state_nx = IDLE;
              rel_nx   = 4'd0;
            end else begin
              state_nx = REL_DB;
              rel_nx   = 4'd1;
            end
          end
        end
        REL_DB: begin
          if (frame_hit && frame_code == cand) begin
            state_nx = HELD;
            rel_nx   = 4'd0;
          end else begin
            rel_nx = rel_cnt + 4'd1;
            if (rel_nx == DB_CNT) begin
              state_nx = IDLE;
              rel_nx   = 4'd0;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    held      = (state == HELD) || (state == REL_DB);
    held_code = held ? cand : '0;
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_nx, rep_inc;
  logic             rep_first, rep_first_nx, rep_push;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_nx;
      rep_first <= rep_first_nx;
    end
  end

  // Frames counted only while staying in HELD; first gap is the delay, then the rate.
  always_comb begin
    rep_cnt_nx   = rep_cnt;
    rep_first_nx = rep_first;
    rep_push     = 1'b0;
    rep_inc      = rep_cnt + REP_W'(1);
    if (state != HELD || state_nx != HELD) begin
      rep_cnt_nx   = '0;
      rep_first_nx = 1'b1;
    end else if (frame_end) begin
      if (rep_first ? (rep_inc == REP_W'(REPEAT_DELAY)) : (rep_inc == REP_W'(REPEAT_RATE))) begin
        rep_push     = 1'b1;
        rep_cnt_nx   = '0;
        rep_first_nx = 1'b0;
      end else begin
        rep_cnt_nx = rep_inc;
      end
    end
  end

  assign push = confirm | rep_push;
`else
  assign push = confirm;
`endif

  assign push_code = cand_nx;
  assign key_valid = (fifo_count != '0);
  assign pop       = key_valid & key_ready;
  assign full      = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign push_ok   = push & (~full | pop);

  // key_code is a register, so the next head is resolved including a same-cycle write.
  always_comb begin
    count_nx = fifo_count;
    if (push_ok && !pop) count_nx = fifo_count + CNT_W'(1);
    else if (!push_ok && pop) count_nx = fifo_count - CNT_W'(1);
    rd_nx = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    if (count_nx == '0) head_nx = '0;
    else if (push_ok && wr_ptr == rd_nx) head_nx = push_code;
    else head_nx = mem[rd_nx];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      key_code   <= '0;
      overflow   <= 1'b0;
    end else begin
      rd_ptr     <= rd_nx;
      fifo_count <= count_nx;
      key_code   <= head_nx;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= push_code;
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Self-checking bench for keypad_scan_fifo (default parameters) against a
// frame-level behavioural model of debounce and FIFO queueing.
module tb_keypad_scan_fifo;

  localparam int ROWS  = 4;
  localparam int COLS  = 3;
  localparam int DEPTH = 4;
  localparam int DB    = 3;
  localparam int FRAME = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  row_out;
  logic [2:0]  col_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        held;
  logic [3:0]  held_code;
  logic [2:0]  fifo_count;
  logic        overflow;

  logic [11:0] keys;
  int          n_checks;
  int          n_fail;
  int          ph;

  int q[$];
  bit m_held;
  int m_hkey;
  int m_last;
  int m_run;
  int m_relrun;
  bit m_ovf;

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(4), .DEBOUNCE_FRAMES(DB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .row_out(row_out), .col_in(col_in),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready), .held(held),
    .held_code(held_code), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Clock edges since reset release, used to find frame boundaries.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) ph <= 0;
    else ph <= ph + 1;
  end

  // The physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_out[r] && keys[r*COLS + c]) col_in[c] = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic int lowest(input logic [11:0] k);
    for (int i = 0; i < ROWS*COLS; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_held = 0; m_hkey = -1; m_last = -1; m_run = 0; m_relrun = 0; m_ovf = 0;
  endtask

  task automatic model_push(input int code);
    if (q.size() < DEPTH) q.push_back(code);
    else m_ovf = 1;
  endtask

  // Press confirms after DB consecutive identical non-empty frames; release after
  // DB consecutive frames not showing the held key.
  task automatic model_frame(input logic [11:0] k);
    int r;
    r = lowest(k);
    if (!m_held) begin
      if (r >= 0 && r == m_last) m_run++;
      else if (r >= 0) m_run = 1;
      else m_run = 0;
      m_last = r;
      if (m_run == DB) begin
        m_held = 1; m_hkey = r; m_run = 0;
        model_push(r);
      end
    end else begin
      if (r != m_hkey) m_relrun++;
      else m_relrun = 0;
      if (m_relrun == DB) begin
        m_held = 0; m_relrun = 0; m_last = -1; m_run = 0;
      end
    end
  endtask

  task automatic frame_step(input logic [11:0] k, input bit pop_at_end);
    keys = k;
    repeat (FRAME - 1) @(posedge sys_clk);
    @(negedge sys_clk);
    if (pop_at_end) key_ready = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    key_ready = 1'b0;
    if (pop_at_end && q.size() > 0) void'(q.pop_front());
    model_frame(k);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; keys = '0; key_ready = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
  endtask

  task automatic align_frame();
    @(negedge sys_clk);
    while (ph % FRAME != 0) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (row_out !== 4'b0001) begin n_fail++; $display("[TB] FAIL reset_row: got %b expected 0001", row_out); end
    n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_code: got %0d expected 0", key_code); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
    n_checks++; if (held !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_held: got %b expected 0", held); end
    n_checks++; if (held_code !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_held_code: got %0d expected 0", held_code); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 2*FRAME; i++) begin
      logic [3:0] exp_row;
      exp_row = 4'(1) << ((i / 4) % ROWS);
      n_checks++; if (row_out !== exp_row) begin n_fail++; $display("[TB] FAIL scan_row cycle %0d: got %b expected %b", i, row_out, exp_row); end
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    model_frame('0);
    model_frame('0);
  endtask

  task automatic test_drain();
    keys = '0;
    key_ready = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      if (q.size() > 0) begin
        n_checks++;
        if (key_valid !== 1'b1 || key_code !== 4'(q[0])) begin
          n_fail++; $display("[TB] FAIL drain_head: got valid=%b code=%0d expected valid=1 code=%0d", key_valid, key_code, q[0]);
        end
      end
      @(posedge sys_clk);
      if (q.size() > 0) void'(q.pop_front());
      @(negedge sys_clk);
    end
    key_ready = 1'b0;
    model_frame('0);
    n_checks++; if (key_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("[TB] FAIL drain_empty: got valid=%b count=%0d expected valid=0 count=0", key_valid, fifo_count); end
  endtask

  task automatic test_clean_press();
    for (int f = 1; f <= 3; f++) begin
      frame_step(12'h020, 0);
      if (f < 3) begin
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL clean_early_valid frame %0d: got %b expected 0", f, key_valid); end
      end
    end
    n_checks++; if (key_valid !== 1'b1 || key_code !== 4'd5) begin n_fail++; $display("[TB] FAIL clean_push: got valid=%b code=%0d expected valid=1 code=5", key_valid, key_code); end
    n_checks++; if (held !== 1'b1 || held_code !== 4'd5) begin n_fail++; $display("[TB] FAIL clean_held: got held=%b code=%0d expected held=1 code=5", held, held_code); end
    for (int f = 1; f <= 3; f++) begin
      frame_step('0, 0);
      if (f < 3) begin
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("[TB] FAIL clean_rel_early frame %0d: got %b expected 1", f, held); end
      end
    end
    n_checks++; if (held !== 1'b0 || held_code !== 4'd0) begin n_fail++; $display("[TB] FAIL clean_release: got held=%b code=%0d expected held=0 code=0", held, held_code); end
    frame_step('0, 0);
    n_checks++; if (fifo_count !== 3'd1 || key_code !== 4'd5) begin n_fail++; $display("[TB] FAIL clean_single: got count=%0d code=%0d expected count=1 code=5", fifo_count, key_code); end
    test_drain();
  endtask

  task automatic test_multi_key();
    for (int f = 0; f < 3; f++) frame_step(12'h081, 0);
    n_checks++; if (fifo_count !== 3'd1 || key_code !== 4'd0 || held_code !== 4'd0) begin n_fail++; $display("[TB] FAIL multi_first: got count=%0d code=%0d held_code=%0d expected 1/0/0", fifo_count, key_code, held_code); end
    for (int f = 1; f <= 6; f++) begin
      frame_step(12'h080, 0);
      if (f == 3) begin
        n_checks++; if (held !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("[TB] FAIL multi_slide_release: got held=%b count=%0d expected held=0 count=1", held, fifo_count); end
      end
      if (f == 5) begin
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("[TB] FAIL multi_slide_early: got count=%0d expected 1", fifo_count); end
      end
    end
    n_checks++; if (fifo_count !== 3'd2 || held_code !== 4'd7) begin n_fail++; $display("[TB] FAIL multi_second: got count=%0d held_code=%0d expected count=2 held_code=7", fifo_count, held_code); end
    for (int f = 0; f < 3; f++) frame_step('0, 0);
    test_drain();
  endtask

  task automatic test_bounce();
    int n;
    n = $urandom_range(2, 9);
    keys = '0;
    for (int i = 0; i < n; i++) begin #3; keys[0] = ~keys[0]; end
    keys[0] = 1'b1;
    align_frame();
    repeat (5*FRAME) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++; if (fifo_count !== 3'd1 || key_code !== 4'd0 || held !== 1'b1 || held_code !== 4'd0) begin n_fail++; $display("[TB] FAIL bounce_press (%0d bounces): got count=%0d code=%0d held=%b expected count=1 code=0 held=1", n, fifo_count, key_code, held); end
    n = $urandom_range(2, 9);
    for (int i = 0; i < n; i++) begin #3; keys[0] = ~keys[0]; end
    keys[0] = 1'b0;
    align_frame();
    repeat (5*FRAME) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++; if (fifo_count !== 3'd1 || held !== 1'b0) begin n_fail++; $display("[TB] FAIL bounce_release (%0d bounces): got count=%0d held=%b expected count=1 held=0", n, fifo_count, held); end
    model_reset();
    q.push_back(0);
    test_drain();
  endtask

  task automatic test_random();
    logic [11:0] k;
    int kind, len;
    for (int seg = 0; seg < 14; seg++) begin
      kind = $urandom_range(0, 3);
      k = '0;
      if (kind >= 1) k = 12'(1) << $urandom_range(0, 11);
      if (kind == 3) k = k | (12'(1) << $urandom_range(0, 11));
      len = $urandom_range(1, 5);
      for (int f = 0; f < len; f++) begin
        frame_step(k, 0);
        n_checks++; if (held !== m_held) begin n_fail++; $display("[TB] FAIL rand_held seg %0d: got %b expected %b", seg, held, m_held); end
        n_checks++; if (held_code !== 4'(m_held ? m_hkey : 0)) begin n_fail++; $display("[TB] FAIL rand_held_code seg %0d: got %0d expected %0d", seg, held_code, m_held ? m_hkey : 0); end
        n_checks++; if (fifo_count !== 3'(q.size()) || key_valid !== (q.size() > 0)) begin n_fail++; $display("[TB] FAIL rand_count seg %0d: got count=%0d valid=%b expected count=%0d", seg, fifo_count, key_valid, q.size()); end
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("[TB] FAIL rand_overflow seg %0d: got %b expected %b", seg, overflow, m_ovf); end
        if (q.size() > 0) begin
          n_checks++; if (key_code !== 4'(q[0])) begin n_fail++; $display("[TB] FAIL rand_head seg %0d: got %0d expected %0d", seg, key_code, q[0]); end
        end
      end
      if (q.size() >= 3) test_drain();
    end
    for (int f = 0; f < 3; f++) frame_step('0, 0);
    test_drain();
  endtask

  task automatic test_fifo_full();
    for (int code = 1; code <= 6; code++) begin
      for (int f = 1; f <= 3; f++) frame_step(12'(1) << code, (code == 5 && f == 3));
      if (code == 4) begin
        n_checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0 || key_code !== 4'd1) begin n_fail++; $display("[TB] FAIL full_fill: got count=%0d ovf=%b code=%0d expected 4/0/1", fifo_count, overflow, key_code); end
      end
      if (code == 5) begin
        n_checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0 || key_code !== 4'd2) begin n_fail++; $display("[TB] FAIL full_push_pop: got count=%0d ovf=%b code=%0d expected 4/0/2", fifo_count, overflow, key_code); end
      end
      for (int f = 0; f < 3; f++) frame_step('0, 0);
    end
    n_checks++; if (fifo_count !== 3'd4 || overflow !== 1'b1 || key_code !== 4'd2) begin n_fail++; $display("[TB] FAIL full_overflow: got count=%0d ovf=%b code=%0d expected 4/1/2", fifo_count, overflow, key_code); end
    test_drain();
  endtask

  task automatic test_reset_mid();
    for (int f = 0; f < 3; f++) frame_step(12'h004, 0);
    for (int f = 0; f < 3; f++) frame_step('0, 0);
    frame_step(12'h010, 0);
    repeat (8) @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    n_checks++; if (row_out !== 4'b0001 || held !== 1'b0 || held_code !== 4'd0) begin n_fail++; $display("[TB] FAIL midrst_scan: got row=%b held=%b code=%0d expected 0001/0/0", row_out, held, held_code); end
    n_checks++; if (fifo_count !== 3'd0 || key_valid !== 1'b0 || key_code !== 4'd0) begin n_fail++; $display("[TB] FAIL midrst_fifo: got count=%0d valid=%b code=%0d expected 0/0/0", fifo_count, key_valid, key_code); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_overflow: got %b expected 0", overflow); end
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    for (int f = 1; f <= 3; f++) begin
      frame_step(12'h010, 0);
      if (f == 2) begin
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("[TB] FAIL midrst_discard: got count=%0d expected 0", fifo_count); end
      end
    end
    n_checks++; if (fifo_count !== 3'd1 || key_code !== 4'd4 || row_out !== 4'b0001) begin n_fail++; $display("[TB] FAIL midrst_restart: got count=%0d code=%0d row=%b expected 1/4/0001", fifo_count, key_code, row_out); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    sys_rst = 1'b1;
    keys = '0;
    key_ready = 1'b0;
    model_reset();
    test_reset();
    test_clean_press();
    test_multi_key();
    test_bounce();
    test_random();
    test_fifo_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
